seq_comparator: RTL and testbench
=================================

# seq_comparator

Parametrised, multi-cycle magnitude comparator that generalises the team's 2-bit combinational comparator to any operand width. It supports signed and unsigned operands and uses a start/busy/done handshake. Operands are compared MSB-first in SLICE-bit slices, one slice per clock, and the comparison ends early at the first differing slice. It sits between datapath registers and control logic where a wide single-cycle compare would limit clock frequency.

## Interface
- WIDTH, default 8: operand width in bits; must be a multiple of SLICE.
- SLICE, default 2: bits compared per cycle; NSLICE = WIDTH/SLICE.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- start  in  1  request pulse; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; result flags are valid from this cycle.
- a_less_b  out  1  result: A < B.
- a_equal_b  out  1  result: A == B.
- a_greater_b  out  1  result: A > B.

## Operation
- States: IDLE and CMP. All outputs are registered.
- Reset values: state = IDLE, busy = 0, done = 0, all three result flags = 0 (the "no result" state), slice index = 0.
- IDLE with start = 1:
  - Capture a, b and signed_mode into internal registers.
  - If signed_mode = 1, invert bit WIDTH-1 of both captured operands (offset-binary conversion), so the unsigned slice compare orders signed values correctly.
  - Clear the result flags to 000, set busy = 1, set slice index = NSLICE-1, go to CMP.
- CMP, each cycle, compare captured slice [idx*SLICE +: SLICE] of A against B:
  - Slices differ: set a_less_b or a_greater_b accordingly, busy = 0, done = 1, go to IDLE.
  - Slices equal and idx = 0: set a_equal_b = 1, busy = 0, done = 1, go to IDLE.
  - Otherwise: decrement idx and stay in CMP.
- After any done, exactly one result flag is 1.
- Result flags hold until the next accepted start clears them.
- start is ignored while busy = 1.
- Changes on a, b or signed_mode after capture have no effect.
- WIDTH % SLICE != 0 is illegal; elaboration must fail.

## Timing
- Edge t samples start = 1 in IDLE. The decision edge is t+k, where k is the 1-based position, counted from the MSB slice, of the first differing slice; k = NSLICE when the operands are equal.
- busy is high from after edge t until edge t+k.
- done and the result flags update at edge t+k; done is high for exactly one cycle.
- Latency is 1 to NSLICE cycles; with SLICE = WIDTH it is always 1.
- A start asserted during the done cycle is accepted (state is already IDLE). This allows back-to-back operations with no idle gap.
- rst asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - No done is produced for the aborted operation.
  - The first rising edge after rst deasserts can accept start.

## Test plan
- Reset, then WIDTH=8, SLICE=2, unsigned, a=0x80, b=0x7F, start -> done one cycle after the start edge; a_greater_b=1, others 0; busy high for 1 cycle.
- a=0x5A, b=0x5A, unsigned -> done after 4 cycles, a_equal_b=1; busy high for exactly 4 cycles.
- a=0x12, b=0x13, unsigned -> operands differ only in the last slice; done after 4 cycles, a_less_b=1.
- a=0xFF, b=0x01, signed_mode=1 -> done after 1 cycle, a_less_b=1. Repeat with signed_mode=0 -> a_greater_b=1, 1 cycle.
- Start with a=0x12, b=0x13; during busy, change a to 0xFF and pulse start -> still a_less_b=1 after 4 cycles, with only one done pulse.
- Start with a=0x5A, b=0x5A; assert rst in cycle 2 -> busy, done and all flags immediately 0, and no done ever appears for this operation. Release rst, start a=0x01, b=0x00 -> a_greater_b after 4 cycles. In that done cycle, start a=0x00, b=0x00 -> accepted, and a_equal_b follows 4 cycles later.

Source files
------------

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, SLICE bits per
// clock, and stops at the first differing slice. Signed operands use offset binary.
module seq_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_less_b,
  output logic             a_equal_b,
  output logic             a_greater_b
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Operand width must split into whole slices.
  if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_width_check
    $fatal(1, "seq_comparator: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_d, done_d, lt_d, eq_d, gt_d;
  logic [SLICE-1:0] slice_a, slice_b;
  logic [WIDTH-1:0] msb_flip;
  int unsigned      base;

  assign base     = 32'(idx_q) * SLICE;
  assign slice_a  = a_q[base +: SLICE];
  assign slice_b  = b_q[base +: SLICE];
  assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CMP;
      CMP:  if (slice_a != slice_b || idx_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    idx_d  = idx_q;
    busy_d = busy;
    done_d = 1'b0;
    lt_d   = a_less_b;
    eq_d   = a_equal_b;
    gt_d   = a_greater_b;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a ^ msb_flip;
          b_d    = b ^ msb_flip;
          idx_d  = IDX_W'(NSLICE - 1);
          busy_d = 1'b1;
          lt_d   = 1'b0;
          eq_d   = 1'b0;
          gt_d   = 1'b0;
        end
      end
      CMP: begin
        if (slice_a != slice_b) begin
          lt_d   = (slice_a < slice_b);
          gt_d   = (slice_a > slice_b);
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (idx_q == '0) begin
          eq_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d  = idx_q - IDX_W'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      a_less_b    <= 1'b0;
      a_equal_b   <= 1'b0;
      a_greater_b <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      busy        <= busy_d;
      done        <= done_d;
      a_less_b    <= lt_d;
      a_equal_b   <= eq_d;
      a_greater_b <= gt_d;
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator (WIDTH=8, SLICE=2): expected flags and
// latency are queued at start and checked when done pulses.
module tb_seq_comparator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SLICE  = 2;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct {
    logic [2:0] flags;
    int         accept;
    int         k;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, a_less_b, a_equal_b, a_greater_b;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         busy_cnt = 0;
  logic [2:0] last_exp = 3'b000;

  seq_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .a_less_b(a_less_b), .a_equal_b(a_equal_b), .a_greater_b(a_greater_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pop and compare on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("flags", {29'd0, a_less_b, a_equal_b, a_greater_b}, {29'd0, e.flags});
          check("latency", cyc - e.accept, e.k);
          check("busy_cycles", busy_cnt, e.k);
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic sm, input logic [2:0] fl, input int k);
    exp_t e;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    e.flags = fl; e.accept = cyc + 1; e.k = k;
    sb_q.push_back(e);
    last_exp = fl;
  endtask

  // Drive one operation: inputs set on a falling edge, start held one cycle.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sm, input logic [2:0] fl, input int k);
    @(negedge clk);
    issue(av, bv, sm, fl, k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
    check("timeout_pending", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    i = 0;
    @(negedge clk);
    while (!done && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check("timeout_done", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] av,
                                              input logic [WIDTH-1:0] bv, input logic sm);
    logic signed [WIDTH-1:0] sa, sbv;
    sa = av; sbv = bv;
    if (sm) return (sa < sbv) ? LT : (sa > sbv) ? GT : EQ;
    return (av < bv) ? LT : (av > bv) ? GT : EQ;
  endfunction

  function automatic int model_k(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] x;
    x = av ^ bv;
    for (int s = NSLICE - 1; s >= 0; s--)
      if (x[s*SLICE +: SLICE] != '0) return NSLICE - s;
    return NSLICE;
  endfunction

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_flags", {29'd0, a_less_b, a_equal_b, a_greater_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h80, 8'h7F, 1'b0, GT, 1);
    wait_idle(20);
    run_op(8'h5A, 8'h5A, 1'b0, EQ, 4);
    wait_idle(20);
    repeat (3) @(negedge clk);
    check("flags_hold", {29'd0, a_less_b, a_equal_b, a_greater_b}, {29'd0, last_exp});
    run_op(8'h12, 8'h13, 1'b0, LT, 4);
    wait_idle(20);
    run_op(8'hFF, 8'h01, 1'b1, LT, 1);
    wait_idle(20);
    run_op(8'hFF, 8'h01, 1'b0, GT, 1);
    wait_idle(20);

    // Start and operand changes while busy are ignored.
    run_op(8'h12, 8'h13, 1'b0, LT, 4);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; signed_mode = 1'b1;
    wait_idle(20);
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    run_op(8'h5A, 8'h5A, 1'b0, EQ, 4);
    @(posedge clk);
    #3;
    check("busy_before_rst", {31'd0, busy}, 1);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_flags", {29'd0, a_less_b, a_equal_b, a_greater_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Back-to-back: new start during the done cycle.
    run_op(8'h01, 8'h00, 1'b0, GT, 4);
    wait_done(20);
    issue(8'h00, 8'h00, 1'b0, EQ, 4);
    @(negedge clk);
    start = 1'b0;
    wait_idle(20);

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra : (i % 3 == 1) ? (ra ^ WIDTH'($urandom_range(1, 3))) : WIDTH'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, model_flags(ra, rb, rs), model_k(ra, rb));
      wait_idle(20);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
